// File: rtl/vga_sync_pattern_gen_if.sv
// Display-side bundle of the VGA generator: sync, active flag, pixel coordinate and colour.
interface vga_sync_pattern_gen_if;
  logic       o_hs;
  logic       o_vs;
  logic       o_activeArea;
  logic [9:0] o_px;
  logic [9:0] o_py;
  logic [2:0] o_red;
  logic [2:0] o_green;
  logic [2:0] o_blue;

  modport master (
    output o_hs, o_vs, o_activeArea, o_px, o_py, o_red, o_green, o_blue
  );

  modport slave (
    input o_hs, o_vs, o_activeArea, o_px, o_py, o_red, o_green, o_blue
  );
endinterface

// File: rtl/vga_sync_pattern_gen.sv
// 640x480@60 VGA timing generator with an animated test pattern, one pixel per clock.
// Coordinate/sync outputs lag the raw counters by one clock; colour lags the coordinate by one more.
module vga_sync_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  vga_sync_pattern_gen_if.master        vga
);

  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic [4:0] r_frame;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_active;
  logic       w_hs;
  logic       w_vs;

  logic [9:0] r_px;
  logic [9:0] r_py;
  logic       r_active;
  logic       r_hs;
  logic       r_vs;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      if (w_v_last) begin
        r_v     <= '0;
        r_frame <= r_frame + 5'd1;
      end else begin
        r_v <= r_v + 10'd1;
      end
    end else begin
      r_h <= r_h + 10'd1;
    end
  end

  assign w_active = (r_h < H_ACT_END) && (r_v < V_ACT_END);
  assign w_hs     = ((r_h >= HS_START) && (r_h < HS_END)) ? SYNC_POL : !SYNC_POL;
  assign w_vs     = ((r_v >= VS_START) && (r_v < VS_END)) ? SYNC_POL : !SYNC_POL;

  // All coordinate-stage outputs come from one register bank so they always describe the same pixel.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_px     <= '0;
      r_py     <= '0;
      r_active <= 1'b0;
      r_hs     <= !SYNC_POL;
      r_vs     <= !SYNC_POL;
    end else begin
      r_px     <= r_h;
      r_py     <= r_v;
      r_active <= w_active;
      r_hs     <= w_hs;
      r_vs     <= w_vs;
    end
  end

  // Per-channel pattern base and frame slice; the frame only changes across blanked pixels.
  logic [2:0] w_base [3];
  logic [2:0] w_fsel [3];
  logic [2:0] w_chan [3];

  assign w_base[0] = r_px[8:6];
  assign w_base[1] = r_py[8:6];
  assign w_base[2] = r_px[5:3] ^ r_py[5:3];
  assign w_fsel[0] = r_frame[2:0];
  assign w_fsel[1] = r_frame[3:1];
  assign w_fsel[2] = r_frame[4:2];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [2:0] r_chan;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          r_chan <= '0;
        end else begin
          r_chan <= r_active ? (w_base[gi] + w_fsel[gi]) : 3'd0;
        end
      end

      assign w_chan[gi] = r_chan;
    end
  endgenerate

  assign vga.o_hs         = r_hs;
  assign vga.o_vs         = r_vs;
  assign vga.o_activeArea = r_active;
  assign vga.o_px         = r_px;
  assign vga.o_py         = r_py;
  assign vga.o_red        = w_chan[0];
  assign vga.o_green      = w_chan[1];
  assign vga.o_blue       = w_chan[2];

endmodule

// File: tb/tb_vga_sync_pattern_gen.sv
// Scoreboard bench: dut0 uses full 640x480 timing, dut1 a shrunken raster so whole frames fit in a short run.
// Expected pixel/colour vectors are queued by cycle number and compared by a negedge monitor.
module tb_vga_sync_pattern_gen;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vga_sync_pattern_gen_if vif0 ();
  vga_sync_pattern_gen_if vif1 ();

  vga_sync_pattern_gen dut0 (
    .i_clk   (clk),
    .i_reset (rst_n),
    .vga     (vif0)
  );

  // Small raster: 100 clocks/line (sync 84..91), 90 lines/frame (sync lines 84..85), 9000 clocks/frame.
  vga_sync_pattern_gen #(
    .H_ACTIVE (80), .H_FP (4), .H_SYNC (8), .H_BP (8),
    .V_ACTIVE (80), .V_FP (4), .V_SYNC (2), .V_BP (4)
  ) dut1 (
    .i_clk   (clk),
    .i_reset (rst_n),
    .vga     (vif1)
  );

  typedef enum int {K_ALL, K_POS, K_RGB} kind_e;

  typedef struct {
    string name;
    int    cyc;
    int    dut;
    kind_e kind;
    int    px, py, hs, vs, act;
    int    r, g, b;
  } vec_t;

  vec_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string name, input int d, input int c, input kind_e k,
                      input int px, input int py, input int hs, input int vs, input int act,
                      input int r, input int g, input int b);
    vec_t v;
    v.name = name; v.cyc = c; v.dut = d; v.kind = k;
    v.px = px; v.py = py; v.hs = hs; v.vs = vs; v.act = act;
    v.r = r; v.g = g; v.b = b;
    sb.push_back(v);
  endtask

  task automatic push_pos(input string name, input int d, input int c,
                          input int px, input int py, input int hs, input int vs, input int act);
    push(name, d, c, K_POS, px, py, hs, vs, act, 0, 0, 0);
  endtask

  task automatic push_rgb(input string name, input int d, input int c,
                          input int r, input int g, input int b);
    push(name, d, c, K_RGB, 0, 0, 0, 0, 0, r, g, b);
  endtask

  task automatic push_rst(input string name, input int c);
    push({name, "_d0"}, 0, c, K_ALL, 0, 0, 1, 1, 0, 0, 0, 0);
    push({name, "_d1"}, 1, c, K_ALL, 0, 0, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic check_vec(input vec_t v);
    int  apx, apy, ahs, avs, aact, ar, ag, ab;
    bit  ok_pos, ok_rgb, ok;
    if (v.dut == 0) begin
      apx = int'(vif0.o_px); apy = int'(vif0.o_py); ahs = int'(vif0.o_hs);
      avs = int'(vif0.o_vs); aact = int'(vif0.o_activeArea);
      ar = int'(vif0.o_red); ag = int'(vif0.o_green); ab = int'(vif0.o_blue);
    end else begin
      apx = int'(vif1.o_px); apy = int'(vif1.o_py); ahs = int'(vif1.o_hs);
      avs = int'(vif1.o_vs); aact = int'(vif1.o_activeArea);
      ar = int'(vif1.o_red); ag = int'(vif1.o_green); ab = int'(vif1.o_blue);
    end
    ok_pos = (apx == v.px) && (apy == v.py) && (ahs == v.hs) && (avs == v.vs) && (aact == v.act);
    ok_rgb = (ar == v.r) && (ag == v.g) && (ab == v.b);
    case (v.kind)
      K_POS:   ok = ok_pos;
      K_RGB:   ok = ok_rgb;
      default: ok = ok_pos && ok_rgb;
    endcase
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s dut%0d cyc=%0d got px=%0d py=%0d hs=%0d vs=%0d act=%0d rgb=%0d,%0d,%0d want px=%0d py=%0d hs=%0d vs=%0d act=%0d rgb=%0d,%0d,%0d",
               v.name, v.dut, v.cyc, apx, apy, ahs, avs, aact, ar, ag, ab,
               v.px, v.py, v.hs, v.vs, v.act, v.r, v.g, v.b);
    end else begin
      $display("ok   %s dut%0d cyc=%0d", v.name, v.dut, v.cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  // Timing measurements taken from the free-running outputs before the mid-frame reset.
  int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1, hs_fall_px = -1;
  int act_rise = -1, act_len = -1;
  int vs_fall1 = -1, vs_fall2 = -1, vs_rise1 = -1;
  int viol = 0;
  bit p0_hs = 1'b1, p0_act = 1'b0, p1_vs = 1'b1;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_vec(sb[i]);
        sb.delete(i);
      end
    end
    if (rst_n && cyc > 10 && cyc < 58000) begin
      if (p0_hs && !vif0.o_hs) begin
        if (hs_fall1 < 0) begin
          hs_fall1   = cyc;
          hs_fall_px = int'(vif0.o_px);
        end else if (hs_fall2 < 0) begin
          hs_fall2 = cyc;
        end
      end
      if (!p0_hs && vif0.o_hs && hs_fall1 >= 0 && hs_rise1 < 0) hs_rise1 = cyc;
      if (!p0_act && vif0.o_activeArea && act_rise < 0) act_rise = cyc;
      if (p0_act && !vif0.o_activeArea && act_rise >= 0 && act_len < 0) act_len = cyc - act_rise;
      if (p1_vs && !vif1.o_vs) begin
        if (vs_fall1 < 0) vs_fall1 = cyc;
        else if (vs_fall2 < 0) vs_fall2 = cyc;
      end
      if (!p1_vs && vif1.o_vs && vs_fall1 >= 0 && vs_rise1 < 0) vs_rise1 = cyc;
      if (vif1.o_activeArea && vif1.o_py >= 10'd80) viol++;
      if (vif0.o_activeArea && vif0.o_py >= 10'd480) viol++;
      p0_hs  = vif0.o_hs;
      p0_act = vif0.o_activeArea;
      p1_vs  = vif1.o_vs;
    end
  end

  task automatic wait_neg(input int c);
    do @(negedge clk); while (cyc != c);
  endtask

  // Pixel index p after a release at cycle 10 is output at cycle 11+p; its colour one cycle later.
  initial begin
    rst_n = 1'b0;

    push_rst("rst_hold", 5);
    push("first_px_d0", 0, 11, K_ALL, 0, 0, 1, 1, 1, 0, 0, 0);
    push("first_px_d1", 1, 11, K_ALL, 0, 0, 1, 1, 1, 0, 0, 0);
    push_pos("px8", 0, 19, 8, 0, 1, 1, 1);
    push_rgb("px8_rgb", 0, 20, 0, 0, 1);
    push_pos("px64", 0, 75, 64, 0, 1, 1, 1);
    push_rgb("px64_rgb", 0, 76, 1, 0, 0);
    push_pos("px639", 0, 650, 639, 0, 1, 1, 1);
    push_rgb("px639_rgb", 0, 651, 1, 0, 7);
    push_pos("px640", 0, 651, 640, 0, 1, 1, 0);
    push_rgb("px640_rgb", 0, 652, 0, 0, 0);
    push_pos("hs_pre", 0, 666, 655, 0, 1, 1, 0);
    push_pos("hs_start", 0, 667, 656, 0, 0, 1, 0);
    push_pos("hs_end", 0, 762, 751, 0, 0, 1, 0);
    push_pos("hs_post", 0, 763, 752, 0, 1, 1, 0);
    push_pos("line_end", 0, 810, 799, 0, 1, 1, 0);
    push("line1", 0, 811, K_ALL, 0, 1, 1, 1, 1, 0, 0, 0);
    push_pos("py72", 0, 57611, 0, 72, 1, 1, 1);
    push_rgb("py72_rgb", 0, 57612, 0, 1, 1);
    push_pos("px100_py72", 0, 57711, 100, 72, 1, 1, 1);
    push_rgb("px100_py72_rgb", 0, 57712, 1, 1, 5);

    push_pos("s_px79", 1, 90, 79, 0, 1, 1, 1);
    push_rgb("s_px79_rgb", 1, 91, 1, 0, 1);
    push_pos("s_hs_pre", 1, 94, 83, 0, 1, 1, 0);
    push_pos("s_hs_start", 1, 95, 84, 0, 0, 1, 0);
    push_pos("s_hs_end", 1, 102, 91, 0, 0, 1, 0);
    push_pos("s_hs_post", 1, 103, 92, 0, 1, 1, 0);
    push_pos("s_last_vis", 1, 7911, 0, 79, 1, 1, 1);
    push_rgb("s_last_vis_rgb", 1, 7912, 0, 1, 1);
    push_pos("s_vblank", 1, 8011, 0, 80, 1, 1, 0);
    push_rgb("s_vblank_rgb", 1, 8012, 0, 0, 0);
    push_pos("s_vs_pre", 1, 8410, 99, 83, 1, 1, 0);
    push_pos("s_vs_start", 1, 8411, 0, 84, 1, 0, 0);
    push_pos("s_vs_end", 1, 8610, 99, 85, 1, 0, 0);
    push_pos("s_vs_post", 1, 8611, 0, 86, 1, 1, 0);
    push_pos("s_frame_end", 1, 9010, 99, 89, 1, 1, 0);
    push("s_frame1", 1, 9011, K_ALL, 0, 0, 1, 1, 1, 0, 0, 0);
    push_rgb("s_frame1_rgb", 1, 9012, 1, 0, 0);
    push_pos("s_f1_79_72", 1, 16290, 79, 72, 1, 1, 1);
    push_rgb("s_f1_79_72_rgb", 1, 16291, 2, 1, 0);
    push_pos("s_f5_origin", 1, 45011, 0, 0, 1, 1, 1);
    push_rgb("s_f5_origin_rgb", 1, 45012, 5, 2, 1);

    // Mid-frame reset asserted between edges; outputs must clear before the next edge.
    push_rst("midrst_async", 58000);
    push_rst("midrst_hold", 58003);
    push("restart_d0", 0, 58006, K_ALL, 0, 0, 1, 1, 1, 0, 0, 0);
    push("restart_d1", 1, 58006, K_ALL, 0, 0, 1, 1, 1, 0, 0, 0);
    push_rgb("restart_rgb_d0", 0, 58007, 0, 0, 0);
    push_rgb("restart_rgb_d1", 1, 58007, 0, 0, 0);
    push_pos("restart_px8", 0, 58014, 8, 0, 1, 1, 1);
    push_rgb("restart_px8_rgb", 0, 58015, 0, 0, 1);
    push_pos("s_restart_px64", 1, 58070, 64, 0, 1, 1, 1);
    push_rgb("s_restart_px64_rgb", 1, 58071, 1, 0, 0);

    wait_neg(10);
    rst_n = 1'b1;
    wait_neg(57999);
    @(posedge clk);
    #3 rst_n = 1'b0;
    wait_neg(58005);
    rst_n = 1'b1;
    wait_neg(58100);

    check_int("hs_low_clocks", hs_rise1 - hs_fall1, 96);
    check_int("hs_fall_px", hs_fall_px, 656);
    check_int("hs_period", hs_fall2 - hs_fall1, 800);
    check_int("active_run", act_len, 640);
    check_int("s_vs_low_clocks", vs_rise1 - vs_fall1, 200);
    check_int("s_vs_period", vs_fall2 - vs_fall1, 9000);
    check_int("active_in_vblank", viol, 0);
    check_int("unsampled_vectors", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
